alu_controlador: RTL and testbench

Sequencer that shares the 4-bit ALU and a 4-entry, 4-bit register file between one command source and a host preload port. It accepts one command per handshake, reads the operands, drives the combinational ALU, and captures the result and flags. It then writes the result back and reports completion. It sits between the instruction source and the ALU instance, which it reaches through its ov*/iv* ALU ports.

---
 rtl/alu_ctrl_pkg.sv | 17 +
 rtl/alu_controlador_if.sv | 24 ++
 rtl/alu_ctrl_banco.sv | 45 ++++
 rtl/alu_controlador.sv | 177 +++++++++++++++++
 tb/tb_alu_controlador.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared types and sizing for the ALU sequencer: state encoding, datapath and register-file widths.
package alu_ctrl_pkg;

  localparam int unsigned W    = 4;
  localparam int unsigned NREG = 4;
  localparam int unsigned AW   = $clog2(NREG);
  localparam int unsigned OPW  = 4;
  localparam int unsigned FW   = 4;

  typedef enum logic [1:0] {
    INACTIVO,
    LEER,
    EJECUTAR,
    ESCRIBIR
  } estado_t;

endpackage

// File: rtl/alu_controlador_if.sv
// Command handshake bus between the instruction source (master) and the sequencer (slave).
interface alu_controlador_if;
  import alu_ctrl_pkg::*;

  logic           iValido;
  logic           oListo;
  logic [OPW-1:0] ivOpcode;
  logic [AW-1:0]  ivDestino;
  logic [AW-1:0]  ivFuenteA;
  logic [AW-1:0]  ivFuenteB;
  logic           iSelInm;
  logic [W-1:0]   ivInmediato;

  modport master (
    output iValido, ivOpcode, ivDestino, ivFuenteA, ivFuenteB, iSelInm, ivInmediato,
    input  oListo
  );

  modport slave (
    input  iValido, ivOpcode, ivDestino, ivFuenteA, ivFuenteB, iSelInm, ivInmediato,
    output oListo
  );

endinterface

// File: rtl/alu_ctrl_banco.sv
// Register file: two asynchronous read ports, one write port shared by write-back and host preload.
module alu_ctrl_banco
  import alu_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] rd_dir_a,
  input  logic [AW-1:0] rd_dir_b,
  output logic [W-1:0]  rd_dato_a,
  output logic [W-1:0]  rd_dato_b,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_dir,
  input  logic [W-1:0]  wb_dato,
  input  logic          host_we,
  input  logic [AW-1:0] host_dir,
  input  logic [W-1:0]  host_dato
);

  logic [W-1:0] regs_q [NREG];
  logic [W-1:0] regs_d [NREG];

  // Write-back wins; the sequencer only opens the host port while idle.
  always_comb begin
    regs_d = regs_q;
    if (wb_we) begin
      regs_d[wb_dir] = wb_dato;
    end else if (host_we) begin
      regs_d[host_dir] = host_dato;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rd_dato_a = regs_q[rd_dir_a];
  assign rd_dato_b = regs_q[rd_dir_b];

endmodule

// File: rtl/alu_controlador.sv
// Four-phase sequencer driving an external ALU from a small register file.
// Optional immediate B operand enabled by defining ALU_CTRL_IMM_EN.
module alu_controlador
  import alu_ctrl_pkg::*;
(
  input  logic             iClk,
  input  logic             iRst_n,
  alu_controlador_if.slave cmd,
  input  logic             iEscribir,
  input  logic [AW-1:0]    ivDirEscritura,
  input  logic [W-1:0]     ivDatoEscritura,
  output logic [OPW-1:0]   ovInstruccion,
  output logic [W-1:0]     ovRegistroA,
  output logic [W-1:0]     ovRegistroB,
  input  logic [W-1:0]     ivResultado,
  input  logic [FW-1:0]    ivFlags,
  output logic [W-1:0]     ovResultado,
  output logic [FW-1:0]    ovFlags,
  output logic             oHecho,
  output logic             oOcupadoErr
);

  estado_t        estado_q, estado_d;
  logic [OPW-1:0] op_q, op_d;
  logic [AW-1:0]  dest_q, dest_d;
  logic [AW-1:0]  fa_q, fa_d;
  logic [AW-1:0]  fb_q, fb_d;
  logic           sel_inm_q, sel_inm_d;
  logic [W-1:0]   inm_q, inm_d;
  logic [OPW-1:0] instr_q, instr_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   res_hold_q, res_hold_d;
  logic [FW-1:0]  flags_hold_q, flags_hold_d;
  logic [W-1:0]   res_q, res_d;
  logic [FW-1:0]  flags_q, flags_d;
  logic           hecho_q, hecho_d;
  logic           err_q, err_d;
  logic           listo_q, listo_d;

  logic           host_we, wb_we, usa_inm;
  logic [W-1:0]   rd_a, rd_b;

`ifdef ALU_CTRL_IMM_EN
  assign usa_inm = sel_inm_q;
`else
  logic unused_inm;
  assign usa_inm    = 1'b0;
  assign unused_inm = ^{sel_inm_q, inm_q};
`endif

  alu_ctrl_banco u_banco (
    .clk       (iClk),
    .rst_n     (iRst_n),
    .rd_dir_a  (fa_q),
    .rd_dir_b  (fb_q),
    .rd_dato_a (rd_a),
    .rd_dato_b (rd_b),
    .wb_we     (wb_we),
    .wb_dir    (dest_q),
    .wb_dato   (res_hold_q),
    .host_we   (host_we),
    .host_dir  (ivDirEscritura),
    .host_dato (ivDatoEscritura)
  );

  always_comb begin
    estado_d     = estado_q;
    op_d         = op_q;
    dest_d       = dest_q;
    fa_d         = fa_q;
    fb_d         = fb_q;
    sel_inm_d    = sel_inm_q;
    inm_d        = inm_q;
    instr_d      = instr_q;
    a_d          = a_q;
    b_d          = b_q;
    res_hold_d   = res_hold_q;
    flags_hold_d = flags_hold_q;
    res_d        = res_q;
    flags_d      = flags_q;
    hecho_d      = 1'b0;
    err_d        = 1'b0;
    host_we      = 1'b0;
    wb_we        = 1'b0;

    case (estado_q)
      INACTIVO: begin
        // A host write on the accept edge lands before LEER reads the file.
        host_we = iEscribir;
        if (cmd.iValido) begin
          op_d      = cmd.ivOpcode;
          dest_d    = cmd.ivDestino;
          fa_d      = cmd.ivFuenteA;
          fb_d      = cmd.ivFuenteB;
          sel_inm_d = cmd.iSelInm;
          inm_d     = cmd.ivInmediato;
          estado_d  = LEER;
        end
      end
      LEER: begin
        instr_d  = op_q;
        a_d      = rd_a;
        b_d      = usa_inm ? inm_q : rd_b;
        estado_d = EJECUTAR;
      end
      EJECUTAR: begin
        res_hold_d   = ivResultado;
        flags_hold_d = ivFlags;
        estado_d     = ESCRIBIR;
      end
      ESCRIBIR: begin
        wb_we    = 1'b1;
        res_d    = res_hold_q;
        flags_d  = flags_hold_q;
        hecho_d  = 1'b1;
        estado_d = INACTIVO;
      end
      default: estado_d = INACTIVO;
    endcase

    if (estado_q != INACTIVO) begin
      err_d = iEscribir;
    end
    listo_d = (estado_d == INACTIVO);
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      estado_q     <= INACTIVO;
      op_q         <= '0;
      dest_q       <= '0;
      fa_q         <= '0;
      fb_q         <= '0;
      sel_inm_q    <= 1'b0;
      inm_q        <= '0;
      instr_q      <= '0;
      a_q          <= '0;
      b_q          <= '0;
      res_hold_q   <= '0;
      flags_hold_q <= '0;
      res_q        <= '0;
      flags_q      <= '0;
      hecho_q      <= 1'b0;
      err_q        <= 1'b0;
      listo_q      <= 1'b1;
    end else begin
      estado_q     <= estado_d;
      op_q         <= op_d;
      dest_q       <= dest_d;
      fa_q         <= fa_d;
      fb_q         <= fb_d;
      sel_inm_q    <= sel_inm_d;
      inm_q        <= inm_d;
      instr_q      <= instr_d;
      a_q          <= a_d;
      b_q          <= b_d;
      res_hold_q   <= res_hold_d;
      flags_hold_q <= flags_hold_d;
      res_q        <= res_d;
      flags_q      <= flags_d;
      hecho_q      <= hecho_d;
      err_q        <= err_d;
      listo_q      <= listo_d;
    end
  end

  assign cmd.oListo    = listo_q;
  assign ovInstruccion = instr_q;
  assign ovRegistroA   = a_q;
  assign ovRegistroB   = b_q;
  assign ovResultado   = res_q;
  assign ovFlags       = flags_q;
  assign oHecho        = hecho_q;
  assign oOcupadoErr   = err_q;

endmodule

// File: tb/tb_alu_controlador.sv
// Bench for alu_controlador: directed scenarios plus random traffic against a transaction-level model.
module tb_alu_controlador;

`ifdef ALU_CTRL_IMM_EN
  localparam bit IMM_ON = 1'b1;
`else
  localparam bit IMM_ON = 1'b0;
`endif

  logic       iClk   = 1'b0;
  logic       iRst_n = 1'b1;
  logic       iEscribir = 1'b0;
  logic [1:0] ivDirEscritura  = '0;
  logic [3:0] ivDatoEscritura = '0;
  logic [3:0] ovInstruccion, ovRegistroA, ovRegistroB;
  logic [3:0] ivResultado, ivFlags, ovResultado, ovFlags;
  logic       oHecho, oOcupadoErr;

  alu_controlador_if cmd_if ();

  alu_controlador dut (
    .iClk            (iClk),
    .iRst_n          (iRst_n),
    .cmd             (cmd_if),
    .iEscribir       (iEscribir),
    .ivDirEscritura  (ivDirEscritura),
    .ivDatoEscritura (ivDatoEscritura),
    .ovInstruccion   (ovInstruccion),
    .ovRegistroA     (ovRegistroA),
    .ovRegistroB     (ovRegistroB),
    .ivResultado     (ivResultado),
    .ivFlags         (ivFlags),
    .ovResultado     (ovResultado),
    .ovFlags         (ovFlags),
    .oHecho          (oHecho),
    .oOcupadoErr     (oOcupadoErr)
  );

  always #5 iClk = ~iClk;

  // Bench ALU: returns {flags, result}. Opcode 0 is add with carry in flags[0].
  function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    int s;
    logic [7:0] r;
    case (op)
      4'd0: begin s = int'(a) + int'(b); r = {3'b000, (s > 15), 4'(s)}; end
      4'd1: begin s = int'(a) - int'(b); r = {3'b000, (s < 0), 4'(s)}; end
      4'd2: r = {4'h0, a & b};
      4'd3: r = {4'h0, a | b};
      4'd4: r = {4'h0, a ^ b};
      4'd5: r = {4'h0, a};
      default: r = {op, ~a};
    endcase
    return r;
  endfunction

  always_comb {ivFlags, ivResultado} = alu_f(ovInstruccion, ovRegistroA, ovRegistroB);

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction model: a command accepted at edge N reads operands at N (after any
  // host write on that edge), shows them on the ALU after N+1, commits at N+3.
  logic [3:0] m_regs [4] = '{default: 4'h0};
  int         cyc     = 0;
  bit         m_busy  = 1'b0;
  int         alu_due = 0;
  int         m_due   = 0;
  logic [1:0] m_dest  = '0;
  logic [3:0] p_instr = '0, p_a = '0, p_b = '0, m_pres = '0, m_pflags = '0;
  logic [3:0] e_instr = '0, e_a = '0, e_b = '0, e_res = '0, e_flags = '0;
  bit         e_hecho = 1'b0, e_err = 1'b0, e_listo = 1'b1;

  always @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      for (int i = 0; i < 4; i++) m_regs[i] = 4'h0;
      cyc = 0; m_busy = 1'b0;
      e_instr = '0; e_a = '0; e_b = '0; e_res = '0; e_flags = '0;
      e_hecho = 1'b0; e_err = 1'b0; e_listo = 1'b1;
    end else begin
      cyc++;
      e_hecho = 1'b0;
      e_err   = m_busy && iEscribir;
      if (m_busy && cyc == alu_due) begin
        e_instr = p_instr; e_a = p_a; e_b = p_b;
      end
      if (m_busy && cyc == m_due) begin
        m_regs[m_dest] = m_pres;
        e_res   = m_pres;
        e_flags = m_pflags;
        e_hecho = 1'b1;
        m_busy  = 1'b0;
      end else if (!m_busy) begin
        if (iEscribir) m_regs[ivDirEscritura] = ivDatoEscritura;
        if (cmd_if.iValido) begin
          p_instr = cmd_if.ivOpcode;
          p_a     = m_regs[cmd_if.ivFuenteA];
          p_b     = (IMM_ON && cmd_if.iSelInm) ? cmd_if.ivInmediato : m_regs[cmd_if.ivFuenteB];
          {m_pflags, m_pres} = alu_f(p_instr, p_a, p_b);
          m_dest  = cmd_if.ivDestino;
          m_busy  = 1'b1;
          alu_due = cyc + 1;
          m_due   = cyc + 3;
        end
      end
      e_listo = !m_busy;
    end
  end

  always @(negedge iClk) begin
    if (chk_en) begin
      cmp("listo",  32'(cmd_if.oListo), 32'(e_listo));
      cmp("hecho",  32'(oHecho),        32'(e_hecho));
      cmp("ocup",   32'(oOcupadoErr),   32'(e_err));
      cmp("res",    32'(ovResultado),   32'(e_res));
      cmp("flags",  32'(ovFlags),       32'(e_flags));
      cmp("instr",  32'(ovInstruccion), 32'(e_instr));
      cmp("alu_a",  32'(ovRegistroA),   32'(e_a));
      cmp("alu_b",  32'(ovRegistroB),   32'(e_b));
    end
  end

  task automatic tick();
    @(posedge iClk);
    #2;
  endtask

  task automatic hwrite(input logic [1:0] d, input logic [3:0] v);
    iEscribir = 1'b1; ivDirEscritura = d; ivDatoEscritura = v;
    tick();
    iEscribir = 1'b0;
  endtask

  task automatic cmd_send(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] ra,
                          input logic [1:0] rb, input logic sel, input logic [3:0] imm,
                          input logic hw, input logic [1:0] hd, input logic [3:0] hv);
    cmd_if.iValido = 1'b1; cmd_if.ivOpcode = op; cmd_if.ivDestino = rd;
    cmd_if.ivFuenteA = ra; cmd_if.ivFuenteB = rb; cmd_if.iSelInm = sel; cmd_if.ivInmediato = imm;
    iEscribir = hw; ivDirEscritura = hd; ivDatoEscritura = hv;
    tick();
    cmd_if.iValido = 1'b0; iEscribir = 1'b0;
  endtask

  task automatic wait_hecho(output int lat);
    lat = -1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (oHecho) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic readback(input logic [1:0] r, output logic [3:0] v);
    int lat;
    cmd_send(4'd5, r, r, r, 1'b0, 4'h0, 1'b0, 2'd0, 4'h0);
    wait_hecho(lat);
    cmp("readback_lat", 32'(lat), 32'd3);
    v = ovResultado;
  endtask

  initial begin
    int lat;
    logic [3:0] v;
    cmd_if.iValido = 1'b0; cmd_if.ivOpcode = '0; cmd_if.ivDestino = '0;
    cmd_if.ivFuenteA = '0; cmd_if.ivFuenteB = '0; cmd_if.iSelInm = 1'b0; cmd_if.ivInmediato = '0;

    #1 iRst_n = 1'b0;
    #2 chk_en = 1'b1;
    cmp("rst_listo", 32'(cmd_if.oListo), 32'd1);
    cmp("rst_res",   32'(ovResultado),   32'd0);
    cmp("rst_hecho", 32'(oHecho),        32'd0);
    tick(); tick();
    iRst_n = 1'b1;
    tick();

    // R1=3, R2=4, R0 = R1+R2
    hwrite(2'd1, 4'd3);
    hwrite(2'd2, 4'd4);
    cmd_send(4'd0, 2'd0, 2'd1, 2'd2, 1'b0, 4'h0, 1'b0, 2'd0, 4'h0);
    wait_hecho(lat);
    cmp("add_latency", 32'(lat), 32'd3);
    cmp("add_res",     32'(ovResultado), 32'd7);
    cmp("add_flags",   32'(ovFlags),     32'd0);
    readback(2'd0, v);
    cmp("r0_is_7", 32'(v), 32'd7);

    // 9+8 wraps to 1 with carry
    hwrite(2'd1, 4'd9);
    hwrite(2'd2, 4'd8);
    cmd_send(4'd0, 2'd3, 2'd1, 2'd2, 1'b0, 4'h0, 1'b0, 2'd0, 4'h0);
    wait_hecho(lat);
    cmp("carry_res",   32'(ovResultado), 32'd1);
    cmp("carry_flags", 32'(ovFlags),     32'd1);
    readback(2'd3, v);
    cmp("r3_is_1", 32'(v), 32'd1);

    // Host write R1=5 on the accept edge, R1+R1
    cmd_send(4'd0, 2'd2, 2'd1, 2'd1, 1'b0, 4'h0, 1'b1, 2'd1, 4'd5);
    wait_hecho(lat);
    cmp("same_edge_res", 32'(ovResultado), 32'hA);

    // Host write while busy is rejected
    cmd_send(4'd0, 2'd0, 2'd2, 2'd3, 1'b0, 4'h0, 1'b0, 2'd0, 4'h0);
    tick();
    iEscribir = 1'b1; ivDirEscritura = 2'd1; ivDatoEscritura = 4'hF;
    tick();
    iEscribir = 1'b0;
    cmp("busy_err_pulse", 32'(oOcupadoErr), 32'd1);
    tick();
    cmp("busy_err_clear", 32'(oOcupadoErr), 32'd0);
    cmp("busy_hecho",     32'(oHecho),      32'd1);
    readback(2'd1, v);
    cmp("r1_unchanged", 32'(v), 32'd5);

    // Immediate operand
    hwrite(2'd2, 4'd2);
    cmd_send(4'd0, 2'd1, 2'd2, 2'd2, 1'b1, 4'd6, 1'b0, 2'd0, 4'h0);
    wait_hecho(lat);
    cmp("imm_res", 32'(ovResultado), IMM_ON ? 32'd8 : 32'd4);

    // Reset during EJECUTAR aborts the command
    cmd_send(4'd0, 2'd2, 2'd1, 2'd1, 1'b0, 4'h0, 1'b0, 2'd0, 4'h0);
    tick();
    iRst_n = 1'b0;
    #1;
    cmp("abort_listo", 32'(cmd_if.oListo), 32'd1);
    cmp("abort_res",   32'(ovResultado),   32'd0);
    cmp("abort_flags", 32'(ovFlags),       32'd0);
    cmp("abort_a",     32'(ovRegistroA),   32'd0);
    cmp("abort_hecho", 32'(oHecho),        32'd0);
    tick();
    iRst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      cmp("abort_no_hecho", 32'(oHecho), 32'd0);
    end
    readback(2'd2, v);
    cmp("abort_dest_zero", 32'(v), 32'd0);

    // Random traffic, including back-to-back commands and one mid-run reset
    for (int i = 0; i < 3000; i++) begin
      cmd_if.iValido     = ($urandom_range(0, 2) != 0);
      cmd_if.ivOpcode    = 4'($urandom_range(0, 7));
      cmd_if.ivDestino   = 2'($urandom);
      cmd_if.ivFuenteA   = 2'($urandom);
      cmd_if.ivFuenteB   = 2'($urandom);
      cmd_if.iSelInm     = 1'($urandom);
      cmd_if.ivInmediato = 4'($urandom);
      iEscribir          = ($urandom_range(0, 3) == 0);
      ivDirEscritura     = 2'($urandom);
      ivDatoEscritura    = 4'($urandom);
      if (i == 1500) iRst_n = 1'b0;
      if (i == 1503) iRst_n = 1'b1;
      tick();
    end
    cmd_if.iValido = 1'b0;
    iEscribir      = 1'b0;
    repeat (6) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
